// File: rtl/sd_video_tg.sv
// sd_video_tg: parametrised NTSC/PAL SD composite-video timing generator with genlock
module sd_video_tg #(
  parameter int C_HW            = 11,
  parameter int C_H_SIZE        = 910,
  parameter int C_FIELD_HL      = 525,
  parameter int C_HSYNC_W       = 66,
  parameter int C_EQU_W         = 33,
  parameter int C_SERR_W        = 66,
  parameter int C_H_BLANK_START = 894,
  parameter int C_H_BLANK_END   = 126,
  parameter int C_VBLANK_HL     = 40,
  parameter int C_BURST_START   = 72,
  parameter int C_BURST_END     = 115,
  parameter int C_H_LOCK_OFS    = 2
) (
  input  logic            CK_i,
  input  logic            XAR_i,
  input  logic            CK_EE_i,
  input  logic            INTERLACE_i,
  input  logic            LOCK_EN_i,
  input  logic            XHD_i,
  input  logic            XVD_i,
  output logic            SYNC_o,
  output logic            BLANK_o,
  output logic            BURST_o,
  output logic            FI_o,
  output logic [C_HW-1:0] H_CTR_o,
  output logic [9:0]      HL_CTR_o,
  output logic            SOF_o
);
  localparam logic [C_HW-1:0] H_LAST     = C_HW'(C_H_SIZE - 1);
  localparam logic [C_HW-1:0] HH         = C_HW'(C_H_SIZE / 2);
  localparam logic [C_HW-1:0] HH_LAST    = C_HW'(C_H_SIZE / 2 - 1);
  localparam logic [C_HW-1:0] EQU_W      = C_HW'(C_EQU_W);
  localparam logic [C_HW-1:0] BROAD_W    = C_HW'(C_H_SIZE / 2 - C_SERR_W);
  localparam logic [C_HW-1:0] HSYNC_W    = C_HW'(C_HSYNC_W);
  localparam logic [C_HW-1:0] HB_START   = C_HW'(C_H_BLANK_START);
  localparam logic [C_HW-1:0] HB_END     = C_HW'(C_H_BLANK_END);
  localparam logic [C_HW-1:0] BU_START   = C_HW'(C_BURST_START);
  localparam logic [C_HW-1:0] BU_END     = C_HW'(C_BURST_END);
  localparam logic [C_HW-1:0] LOCK_OFS   = C_HW'(C_H_LOCK_OFS);
  localparam logic [9:0]      HL_IL_LAST = 10'(C_FIELD_HL - 1);
  localparam logic [9:0]      HL_PR_LAST = 10'(C_FIELD_HL - 2);
  localparam logic [9:0]      VBL        = 10'(C_VBLANK_HL);

  logic [C_HW-1:0] h_q, h_d, hp;
  logic [9:0]      hl_q, hl_d;
  logic [1:0]      xhd_q, xhd_d, xvd_q, xvd_d;
  logic            fi_q, fi_d, il_q, il_d, sof_q, sof_d;
  logic            sync_q, sync_d, blank_q, blank_d, burst_q, burst_d;
  logic            xhd_fall, xvd_fall, hb, wrap, vblank, eq_hl, broad_hl, sync_low;

  // Genlock fall detection and counter next state; il_q holds the field mode latched at field start
  always_comb begin
    xhd_d    = {xhd_q[0], XHD_i};
    xvd_d    = {xvd_q[0], XVD_i};
    xhd_fall = LOCK_EN_i & xhd_q[1] & ~xhd_q[0];
    xvd_fall = LOCK_EN_i & xvd_q[1] & ~xvd_q[0];
    hb       = (h_q == HH_LAST) || (h_q == H_LAST);
    wrap     = hb && (hl_q == (il_q ? HL_IL_LAST : HL_PR_LAST));
    h_d      = xhd_fall ? LOCK_OFS : (h_q == H_LAST) ? '0 : h_q + 1'b1;
    hl_d     = (xvd_fall || wrap) ? '0 : hb ? hl_q + 1'b1 : hl_q;
    fi_d     = xvd_fall ? (INTERLACE_i & (h_q >= HH)) : wrap ? (INTERLACE_i & ~fi_q) : fi_q;
    il_d     = (xvd_fall || wrap) ? INTERLACE_i : il_q;
    sof_d    = xvd_fall || wrap;
  end

  // Composite sync, blank and burst decoded from the live counters
  always_comb begin
    hp       = (h_q >= HH) ? h_q - HH : h_q;
    eq_hl    = (hl_q < 10'd6) || ((hl_q >= 10'd12) && (hl_q < 10'd18));
    broad_hl = (hl_q >= 10'd6) && (hl_q < 10'd12);
    vblank   = hl_q < VBL;
    sync_low = eq_hl ? (hp < EQU_W) : broad_hl ? (hp < BROAD_W) : (h_q < HSYNC_W);
    sync_d   = ~sync_low;
    blank_d  = vblank || (h_q >= HB_START) || (h_q < HB_END);
    burst_d  = !vblank && (h_q >= BU_START) && (h_q < BU_END);
  end

  // State registers; CK_EE_i gates every flop, synchronisers included
  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      h_q     <= '0;
      hl_q    <= '0;
      fi_q    <= 1'b0;
      il_q    <= 1'b1;
      sof_q   <= 1'b0;
      sync_q  <= 1'b1;
      blank_q <= 1'b1;
      burst_q <= 1'b0;
      xhd_q   <= 2'b11;
      xvd_q   <= 2'b11;
    end else if (CK_EE_i) begin
      h_q     <= h_d;
      hl_q    <= hl_d;
      fi_q    <= fi_d;
      il_q    <= il_d;
      sof_q   <= sof_d;
      sync_q  <= sync_d;
      blank_q <= blank_d;
      burst_q <= burst_d;
      xhd_q   <= xhd_d;
      xvd_q   <= xvd_d;
    end
  end

  assign SYNC_o   = sync_q;
  assign BLANK_o  = blank_q;
  assign BURST_o  = burst_q;
  assign FI_o     = fi_q;
  assign H_CTR_o  = h_q;
  assign HL_CTR_o = hl_q;
  assign SOF_o    = sof_q;
endmodule
